// File: rtl/aes_inv_key_expansion.sv
// ---------------------------------------------------------------------------
// aes_inv_key_expansion
//   Reverse AES-128 key schedule for the decryption datapath. Loads the final
//   (round 10) key and streams round keys 10, 9, ..., 0 over valid/ready.
//   Output packing matches the forward key expansion: key_out = {w3,w2,w1,w0},
//   each word carrying its first byte in bits [31:24].
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset
//   start      load request, accepted only while idle (busy=0)
//   key_in     round-10 key; byte 0 in [7:0], byte 15 in [127:120]
//   key_ready  consumer accepts key_out this cycle
//   key_out    current round key {w3,w2,w1,w0}
//   key_valid  key_out / round_idx valid
//   round_idx  round number of key_out (10 down to 0)
//   busy       high from start acceptance until done
//   done       one-cycle pulse after round 0 has been accepted
//
// Optional build macro
//   AES_INV_KEY_ZEROIZE_EN : clear the key registers and rcon when the last
//   key is accepted, so key_out reads 0 in DONE and IDLE. When undefined the
//   round-0 (cipher) key stays visible on key_out until the next start/reset.
// ---------------------------------------------------------------------------

// Clocked AES S-box: one byte in, registered substituted byte out.
module aes_inv_key_sbox (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  logic [7:0] dout_r;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        p = p ^ aa;
      end else begin
        p = p;
      end
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0 as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) begin
        r = gf_mul(r, p);
      end else begin
        r = r;
      end
      p = gf_mul(p, p);
    end
    return r;
  endfunction

  // Forward S-box: inverse followed by the affine transform.
  function automatic logic [7:0] sbox_fn(input logic [7:0] a);
    logic [7:0] x;
    x = gf_inv(a);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
             ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  // Substitution output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_r <= 8'h00;
    end else begin
      dout_r <= sbox_fn(din);
    end
  end

  assign dout = dout_r;

endmodule

module aes_inv_key_expansion #(
  parameter int         NUM_ROUNDS = 10,
  parameter logic [7:0] RCON_INIT  = 8'h36
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         key_ready,
  output logic [127:0] key_out,
  output logic         key_valid,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_VALID = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        load_s;
  logic        step_s;
  logic        finish_s;

  logic [31:0] r0_r, r1_r, r2_r, r3_r;
  logic [7:0]  rcon_r;
  logic [3:0]  round_r;
  logic        key_valid_r;
  logic        busy_r;
  logic        done_r;

  logic [31:0] t_s;
  logic [31:0] rot_s;
  logic [31:0] sub_s;

  // Byte reversal of one key_in word into the {first byte in [31:24]} layout.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Inverse Rcon step: divide by x in GF(2^8) (0x8d = x^-1 reduction term).
  function automatic logic [7:0] rcon_prev(input logic [7:0] rc);
    return rc[0] ? ((rc >> 1) ^ 8'h8d) : (rc >> 1);
  endfunction

  // R3^R2 is the new w3 after a step, i.e. the word that fed SubWord on the
  // forward side; the sboxes track it continuously and settle during WAIT.
  assign t_s   = r3_r ^ r2_r;
  assign rot_s = {t_s[23:16], t_s[15:8], t_s[7:0], t_s[31:24]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      aes_inv_key_sbox u_sbox (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (rot_s[gi*8 +: 8]),
        .dout (sub_s[gi*8 +: 8])
      );
    end
  endgenerate

  // FSM next-state and control strobes.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    step_s      = 1'b0;
    finish_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          load_s      = 1'b1;
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        state_nxt_s = ST_VALID;
      end
      ST_VALID: begin
        if (key_ready) begin
          if (round_r != 4'd0) begin
            step_s      = 1'b1;
            state_nxt_s = ST_WAIT;
          end else begin
            finish_s    = 1'b1;
            state_nxt_s = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_VALID;
        end
      end
      ST_DONE: begin
        // start is deliberately not looked at here.
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      key_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      key_valid_r <= (state_nxt_s == ST_VALID);
      busy_r      <= (state_nxt_s == ST_WAIT) || (state_nxt_s == ST_VALID);
      done_r      <= (state_nxt_s == ST_DONE);
    end
  end

  // Key words, rcon and round counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0_r    <= 32'h0000_0000;
      r1_r    <= 32'h0000_0000;
      r2_r    <= 32'h0000_0000;
      r3_r    <= 32'h0000_0000;
      rcon_r  <= RCON_INIT;
      round_r <= 4'd0;
    end else if (load_s) begin
      r0_r    <= bswap32(key_in[31:0]);
      r1_r    <= bswap32(key_in[63:32]);
      r2_r    <= bswap32(key_in[95:64]);
      r3_r    <= bswap32(key_in[127:96]);
      rcon_r  <= RCON_INIT;
      round_r <= 4'(NUM_ROUNDS);
    end else if (step_s) begin
      r3_r    <= r3_r ^ r2_r;
      r2_r    <= r2_r ^ r1_r;
      r1_r    <= r1_r ^ r0_r;
      r0_r    <= r0_r ^ sub_s ^ {rcon_r, 24'h00_0000};
      rcon_r  <= rcon_prev(rcon_r);
      round_r <= round_r - 4'd1;
`ifdef AES_INV_KEY_ZEROIZE_EN
    end else if (finish_s) begin
      // Cleared as DONE is entered so key_out already reads 0 in DONE.
      r0_r    <= 32'h0000_0000;
      r1_r    <= 32'h0000_0000;
      r2_r    <= 32'h0000_0000;
      r3_r    <= 32'h0000_0000;
      rcon_r  <= 8'h00;
      round_r <= round_r;
`endif
    end else begin
      r0_r    <= r0_r;
      r1_r    <= r1_r;
      r2_r    <= r2_r;
      r3_r    <= r3_r;
      rcon_r  <= rcon_r;
      round_r <= round_r;
    end
  end

  assign key_out   = {r3_r, r2_r, r1_r, r0_r};
  assign key_valid = key_valid_r;
  assign round_idx = round_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_aes_inv_key_expansion.sv
// Scoreboard bench for aes_inv_key_expansion using the FIPS-197 A.1 schedule.
module tb_aes_inv_key_expansion;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         key_ready;
  logic [127:0] key_out;
  logic         key_valid;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;

  typedef struct packed {
    logic [127:0] key;
    logic [3:0]   rnd;
  } exp_t;

  exp_t         sb_q[$];
  logic [127:0] rk [0:10];
  int           errors;
  int           checks;
  int           hs_count;
  int           done_count;

  localparam logic [127:0] KEY_A1  = 128'ha60c63b6c80c3fe18925eec9a8f914d0;
  localparam logic [127:0] KEY_ALT = 128'h0123456789abcdeffedcba9876543210;

  aes_inv_key_expansion dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .key_ready(key_ready),
    .key_out  (key_out),
    .key_valid(key_valid),
    .round_idx(round_idx),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted key is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (rst_n && key_valid && key_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_key: got round %0d key %h, expected none", round_idx, key_out);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_key", key_out, e.key);
        check("sb_round", {124'h0, round_idx}, {124'h0, e.rnd});
      end
      hs_count++;
    end
    if (done) begin
      done_count++;
    end
  end

  task automatic push_run();
    for (int r = 10; r >= 0; r--) begin
      exp_t e;
      e.key = rk[r];
      e.rnd = 4'(r);
      sb_q.push_back(e);
    end
  endtask

  task automatic do_start(input logic [127:0] k);
    @(negedge clk);
    key_in = k;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    key_in = 128'h0;
  endtask

  task automatic wait_round(input int r, input string nm);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(posedge clk);
      #1;
      if (key_valid && round_idx == 4'(r)) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: round %0d not seen within 200 cycles, expected it", nm, r);
    end
  endtask

  task automatic wait_done(input string nm);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: done not seen within 200 cycles, expected pulse", nm);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_valid;
    int r0_cyc;
    int done_cyc;
    int hs0;
    int dc0;
    logic [127:0] idle_key;

    // FIPS-197 A.1 round keys as {w3,w2,w1,w0}.
    rk[0]  = 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516;
    rk[1]  = 128'h2a6c7605_23a33939_88542cb1_a0fafe17;
    rk[2]  = 128'h7359f67f_5935807a_7a96b943_f2c295f2;
    rk[3]  = 128'h6d7a883b_1e237e44_4716fe3e_3d80477d;
    rk[4]  = 128'hdb0bad00_b671253b_a8525b7f_ef44a541;
    rk[5]  = 128'h11f915bc_caf2b8bc_7c839d87_d4d1c6f8;
    rk[6]  = 128'hca0093fd_dbf98641_110b3efd_6d88a37a;
    rk[7]  = 128'h4ea6dc4f_84a64fb2_5f5fc9f3_4e54f70e;
    rk[8]  = 128'h7f8d292f_312bf560_b58dbad2_ead27321;
    rk[9]  = 128'h575c006e_28d12941_19fadc21_ac7766f3;
    rk[10] = 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8;

    errors = 0; checks = 0; hs_count = 0; done_count = 0;
    rst_n = 1'b0; start = 1'b0; key_in = 128'h0; key_ready = 1'b0;

`ifdef AES_INV_KEY_ZEROIZE_EN
    idle_key = 128'h0;
`else
    idle_key = 128'h09cf4f3cabf7158828aed2a6_2b7e1516;
`endif

    // Reset state.
    #12;
    check("rst_key_out", key_out, 128'h0);
    check("rst_flags", {124'h0, key_valid, busy, done, 1'b0}, 128'h0);
    check("rst_round", {124'h0, round_idx}, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // FIPS A.1 with key_ready tied high: latency and ordering.
    key_ready = 1'b1;
    push_run();
    do_start(KEY_A1);
    first_valid = -1; r0_cyc = -1; done_cyc = -1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (cyc == 1) check("busy_c1", {127'h0, busy}, 128'h1);
      if (key_valid && round_idx == 4'd10 && first_valid < 0) first_valid = cyc;
      if (key_valid && round_idx == 4'd0 && r0_cyc < 0) r0_cyc = cyc;
      if (done && done_cyc < 0) done_cyc = cyc;
    end
    check("lat_round10", 128'(first_valid), 128'd2);
    check("lat_round0", 128'(r0_cyc), 128'd22);
    check("lat_done", 128'(done_cyc), 128'd23);
    check("run1_keys", 128'(hs_count), 128'd11);
    check("idle_key_out", key_out, idle_key);
    check("idle_flags", {125'h0, key_valid, busy, done}, 128'h0);

    // Backpressure at round 9.
    hs0 = hs_count;
    dc0 = done_count;
    push_run();
    do_start(KEY_A1);
    wait_round(9, "bp_wait9");
    key_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_key", key_out, rk[9]);
      check("bp_hold_vr", {123'h0, key_valid, round_idx}, {123'h0, 1'b1, 4'd9});
    end
    key_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_wait_gap", {127'h0, key_valid}, 128'h0);
    @(posedge clk);
    #1;
    check("bp_round8", {123'h0, key_valid, round_idx}, {123'h0, 1'b1, 4'd8});
    wait_done("bp_done");
    repeat (3) @(posedge clk);
    #1;
    check("bp_keys", 128'(hs_count - hs0), 128'd11);
    check("bp_done_once", 128'(done_count - dc0), 128'd1);

    // start while busy is ignored.
    hs0 = hs_count;
    dc0 = done_count;
    push_run();
    do_start(KEY_A1);
    wait_round(5, "sb_wait5");
    key_in = KEY_ALT;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    key_in = 128'h0;
    wait_done("sb_done");
    repeat (3) @(posedge clk);
    #1;
    check("busy_start_keys", 128'(hs_count - hs0), 128'd11);
    check("busy_start_done_once", 128'(done_count - dc0), 128'd1);
    check("busy_start_idle", {127'h0, busy}, 128'h0);

    // Asynchronous reset mid-run, then restart.
    push_run();
    do_start(KEY_A1);
    wait_round(6, "rst_wait6");
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_key_out", key_out, 128'h0);
    check("mid_rst_flags", {123'h0, key_valid, busy, done, 2'b00}, 128'h0);
    check("mid_rst_round", {124'h0, round_idx}, 128'h0);
    sb_q.delete();
    dc0 = done_count;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_no_done", 128'(done_count - dc0), 128'd0);
    hs0 = hs_count;
    push_run();
    do_start(KEY_A1);
    check("restart_c1_valid", {127'h0, key_valid}, 128'h0);
    @(posedge clk);
    #1;
    check("restart_c2", {123'h0, key_valid, round_idx}, {123'h0, 1'b1, 4'd10});
    check("restart_c2_key", key_out, rk[10]);
    wait_done("restart_done");
    repeat (3) @(posedge clk);
    #1;
    check("restart_keys", 128'(hs_count - hs0), 128'd11);
    check("restart_idle_key", key_out, idle_key);
    check("sb_empty", 128'(sb_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
